display_scan_ctrl: RTL

DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

---
 rtl/disp_pkg.sv | 30 +++
 rtl/display_scan_ctrl_next_sel.sv | 46 ++++
 rtl/display_scan_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/disp_pkg.sv
// ----------------------------------------------------------------------------
// disp_pkg
// Shared types and defaults for the multiplexed 7-segment scan controller.
//   state_t       : scan FSM states (IDLE, SHOW, BLANK)
//   seg_t         : one 7-segment pattern, bit order g..a
//   DEF_*         : default slot / blank / blink timing
//   cnt_width()   : counter width able to hold 0..max(a,b)-1
// ----------------------------------------------------------------------------
package disp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHOW  = 2'd1,
        BLANK = 2'd2
    } state_t;

    typedef logic [6:0] seg_t;

    localparam int DEF_SLOT_CYC    = 50000;
    localparam int DEF_BLANK_CYC   = 16;
    localparam int DEF_BLINK_SLOTS = 250;

    // Counters run 0..len-1, so clog2 of the longest interval is enough.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/display_scan_ctrl_next_sel.sv
// ----------------------------------------------------------------------------
// scan_next_sel
// Combinational search for the next digit to light.
//   dig_en   : per-digit enable mask
//   cur_idx  : index of the digit just shown
//   next_idx : lowest enabled index above cur_idx, else lowest enabled index
//   wrap     : next_idx came from wrapping around to the bottom
//   none     : no digit enabled at all
// ----------------------------------------------------------------------------
module scan_next_sel #(
    parameter int N_DIG = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_DIG-1:0] dig_en,
    input  logic [IDX_W-1:0] cur_idx,
    output logic [IDX_W-1:0] next_idx,
    output logic             wrap,
    output logic             none
);

    logic [IDX_W-1:0] lowest;
    logic [IDX_W-1:0] above;
    logic             found;

    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // otherwise synthesis infers a latch to hold the old value.
        lowest = '0;
        above  = '0;
        found  = 1'b0;
        // Walking downward leaves the smallest qualifying index in each result.
        for (int i = N_DIG - 1; i >= 0; i--) begin
            if (dig_en[i]) begin
                lowest = IDX_W'(i);
                if (IDX_W'(i) > cur_idx) begin
                    above = IDX_W'(i);
                    found = 1'b1;
                end
            end
        end
        none     = ~|dig_en;
        next_idx = found ? above : lowest;
        wrap     = !found && !none;
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// ----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexed driver for N_DIG 7-segment digits sharing one segment bus.
// Each enabled digit is lit for SLOT_CYC cycles, followed by BLANK_CYC dark
// cycles, in ascending index order with wrap-around.
//
// Ports:
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   seg_in     : N_DIG active-high patterns, digit i at [7i+6:7i], g..a
//   dig_en     : per-digit enable, sampled only when choosing the next digit
//   blink_mask : (DISPLAY_BLINK_EN only) digits that blink
//   seg_n      : active-low segment bus, pattern captured at slot start
//   anode_n    : active-low digit selects, at most one low
//   digit_idx  : index of the current or last lit digit
//   frame_done : one-cycle pulse on the first cycle of a slot after a wrap
//
// Build option: define DISPLAY_BLINK_EN to add blink_mask and BLINK_SLOTS.
// A blinking digit keeps its slot timing but its anode stays high during the
// off phase; the phase toggles every BLINK_SLOTS slot starts.
// ----------------------------------------------------------------------------
module display_scan_ctrl
    import disp_pkg::*;
#(
    parameter int N_DIG       = 4,
    parameter int SLOT_CYC    = DEF_SLOT_CYC,
    parameter int BLANK_CYC   = DEF_BLANK_CYC,
`ifdef DISPLAY_BLINK_EN
    parameter int BLINK_SLOTS = DEF_BLINK_SLOTS,
`endif
    localparam int IDX_W      = (N_DIG > 1) ? $clog2(N_DIG) : 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_DIG*7-1:0]   seg_in,
    input  logic [N_DIG-1:0]     dig_en,
`ifdef DISPLAY_BLINK_EN
    input  logic [N_DIG-1:0]     blink_mask,
`endif
    output seg_t                 seg_n,
    output logic [N_DIG-1:0]     anode_n,
    output logic [IDX_W-1:0]     digit_idx,
    output logic                 frame_done
);

    localparam int               CNT_W      = cnt_width(SLOT_CYC, BLANK_CYC);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] TOP_IDX    = IDX_W'(N_DIG - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic [IDX_W-1:0] cur_idx;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_wrap;
    logic             sel_none;
    seg_t             sel_seg;
    logic [N_DIG-1:0] sel_anode_n;
    logic             sel_dark;

    logic             slot_end;
    logic             blank_end;
    logic             at_decision;
    logic             go_show;
    logic             go_idle;

    // From IDLE, searching "above the top index" always wraps, which yields
    // the lowest enabled digit without a second search instance.
    assign cur_idx = (state == IDLE) ? TOP_IDX : digit_idx;

    scan_next_sel #(
        .N_DIG (N_DIG),
        .IDX_W (IDX_W)
    ) u_next_sel (
        .dig_en   (dig_en),
        .cur_idx  (cur_idx),
        .next_idx (sel_idx),
        .wrap     (sel_wrap),
        .none     (sel_none)
    );

    always_comb begin
        sel_seg     = '0;
        sel_anode_n = '1;
        for (int i = 0; i < N_DIG; i++) begin
            if (IDX_W'(i) == sel_idx) begin
                sel_seg        = seg_in[i*7 +: 7];
                sel_anode_n[i] = 1'b0;
            end
        end
    end

    assign slot_end    = (state == SHOW)  && (cnt == SLOT_LAST);
    assign blank_end   = (state == BLANK) && (cnt == BLANK_LAST);
    // With no blank interval the end of a slot is itself the decision point.
    assign at_decision = (BLANK_CYC == 0) ? slot_end : blank_end;
    assign go_show     = !sel_none && (at_decision || (state == IDLE));
    assign go_idle     =  sel_none && at_decision;

`ifdef DISPLAY_BLINK_EN
    localparam int BLINK_W = (BLINK_SLOTS < 2) ? 1 : $clog2(BLINK_SLOTS);

    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_on;

    // The slot being entered uses the phase in force before this entry counts.
    assign sel_dark = !blink_on && |(blink_mask & ~sel_anode_n);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (go_show) begin
            if (blink_cnt == BLINK_W'(BLINK_SLOTS - 1)) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end
`else
    assign sel_dark = 1'b0;
`endif

    // seg_n doubles as the capture register: it holds the inverted pattern
    // for the whole slot and is forced dark outside SHOW.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            seg_n      <= '1;
            anode_n    <= '1;
            digit_idx  <= '0;
            frame_done <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from
            // pre-edge values, independent of statement order.
            frame_done <= 1'b0;
            if (go_show) begin
                state      <= SHOW;
                cnt        <= '0;
                digit_idx  <= sel_idx;
                seg_n      <= ~sel_seg;
                anode_n    <= sel_dark ? '1 : sel_anode_n;
                frame_done <= sel_wrap && (state != IDLE);
            end else if (go_idle) begin
                state   <= IDLE;
                cnt     <= '0;
                seg_n   <= '1;
                anode_n <= '1;
            end else if (slot_end) begin
                state   <= BLANK;
                cnt     <= '0;
                seg_n   <= '1;
                anode_n <= '1;
            end else if (state != IDLE) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
